// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Optional MD_MADD_EN enables op 7 (madd: signed multiply-accumulate into {hi,lo}).
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {ST_IDLE, ST_RUN} state_e;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;
`ifdef MD_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd7;
`endif

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES - 1);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES - 1);

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_wr_q, pend_wr_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  // Arithmetic datapath: all results are formed combinationally from a/b at the start edge.
  logic [63:0] a_sx, b_sx, prod_s, prod_u;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_mag_safe, b_safe;
  logic [31:0] sq_mag, sr_mag, sq, sr, uq, ur;

  always_comb begin
    a_sx   = {{32{a[31]}}, a};
    b_sx   = {{32{b[31]}}, b};
    prod_s = a_sx * b_sx;
    prod_u = {32'd0, a} * {32'd0, b};

    a_neg      = a[31];
    b_neg      = b[31];
    a_mag      = a_neg ? (32'd0 - a) : a;
    b_mag      = b_neg ? (32'd0 - b) : b;
    // Divisor forced non-zero so the divider never sees x/0; the zero case is
    // suppressed at commit through pend_wr.
    b_mag_safe = (b == 32'd0) ? 32'd1 : b_mag;
    b_safe     = (b == 32'd0) ? 32'd1 : b;

    // Magnitude divide then re-sign: 0x80000000 / -1 falls out as 0x80000000 rem 0.
    sq_mag = a_mag / b_mag_safe;
    sr_mag = a_mag % b_mag_safe;
    sq     = (a_neg ^ b_neg) ? (32'd0 - sq_mag) : sq_mag;
    sr     = a_neg ? (32'd0 - sr_mag) : sr_mag;
    uq     = a / b_safe;
    ur     = a % b_safe;
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !cancel) begin
          case (op)
            OP_MULT: begin
              {pend_hi_d, pend_lo_d} = prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = ST_RUN;
            end
            OP_MULTU: begin
              {pend_hi_d, pend_lo_d} = prod_u;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = ST_RUN;
            end
            OP_DIV: begin
              pend_hi_d = sr;
              pend_lo_d = sq;
              pend_wr_d = (b != 32'd0);
              cnt_d     = DIV_LOAD;
              state_d   = ST_RUN;
            end
            OP_DIVU: begin
              pend_hi_d = ur;
              pend_lo_d = uq;
              pend_wr_d = (b != 32'd0);
              cnt_d     = DIV_LOAD;
              state_d   = ST_RUN;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
`ifdef MD_MADD_EN
            OP_MADD: begin
              {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
              pend_wr_d = 1'b1;
              cnt_d     = MULT_LOAD;
              state_d   = ST_RUN;
            end
`endif
            default: ;
          endcase
        end
      end

      ST_RUN: begin
        if (cancel) begin
          state_d   = ST_IDLE;
          cnt_d     = 5'd0;
          pend_hi_d = 32'd0;
          pend_lo_d = 32'd0;
          pend_wr_d = 1'b0;
        end else if (cnt_q == 5'd0) begin
          state_d = ST_IDLE;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 5'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed test-plan steps followed by random ops,
// checked against a 64-bit arithmetic reference model of HI/LO and latency.
module tb_md_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cancel = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] hi_m, lo_m;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: applies one op to hi_m/lo_m and returns its busy latency.
  task automatic model_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                          output int lat);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa  = longint'($signed(aa));
    sb  = longint'($signed(bb));
    lat = 0;
    case (o)
      3'd1: begin p = 64'(sa * sb); {hi_m, lo_m} = p; lat = MULT_N; end
      3'd2: begin p = {32'd0, aa} * {32'd0, bb}; {hi_m, lo_m} = p; lat = MULT_N; end
      3'd3: begin
        lat = DIV_N;
        if (bb != 0) begin
          q = sa / sb;
          r = sa % sb;
          lo_m = q[31:0];
          hi_m = r[31:0];
        end
      end
      3'd4: begin
        lat = DIV_N;
        if (bb != 0) begin
          lo_m = aa / bb;
          hi_m = aa % bb;
        end
      end
      3'd5: hi_m = aa;
      3'd6: lo_m = aa;
`ifdef MD_MADD_EN
      3'd7: begin p = {hi_m, lo_m} + 64'(sa * sb); {hi_m, lo_m} = p; lat = MULT_N; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op, count busy cycles, verify hi/lo stay frozen while busy, then check result.
  task automatic do_op(input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input string tag);
    int          lat, cnt;
    logic [31:0] hi_old, lo_old;
    hi_old = hi_m;
    lo_old = lo_m;
    model_op(o, aa, bb, lat);
    start = 1'b1; op = o; a = aa; b = bb;
    tick();
    start = 1'b0; op = 3'd0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 64) begin
      chk({tag, " hi_frozen"}, hi, hi_old);
      chk({tag, " lo_frozen"}, lo, lo_old);
      cnt++;
      tick();
    end
    chk({tag, " busy_cycles"}, 32'(cnt), 32'(lat));
    chk({tag, " hi"}, hi, hi_m);
    chk({tag, " lo"}, lo, lo_m);
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic [31:0] ra, rb;
    logic [2:0]  ro;

    // Reset
    tick(); tick();
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;

    // Multiply / divide directed cases
    do_op(3'd1, 32'hFFFF_FFFE, 32'd3, "mult -2*3");
    chk("mult -2*3 hi const", hi, 32'hFFFF_FFFF);
    chk("mult -2*3 lo const", lo, 32'hFFFF_FFFA);
    do_op(3'd2, 32'hFFFF_FFFE, 32'd3, "multu");
    chk("multu hi const", hi, 32'h0000_0002);
    do_op(3'd3, 32'hFFFF_FFF9, 32'd2, "div -7/2");
    chk("div -7/2 lo const", lo, 32'hFFFF_FFFD);
    chk("div -7/2 hi const", hi, 32'hFFFF_FFFF);
    do_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
    chk("div ovf lo const", lo, 32'h8000_0000);
    do_op(3'd4, 32'd1234, 32'd0, "divu by0");
    do_op(3'd3, 32'd77, 32'd0, "div by0");
    do_op(3'd4, 32'hFFFF_FFF0, 32'd7, "divu");

    // mthi / mtlo in IDLE: one-cycle visibility, no busy
    do_op(3'd5, 32'h1234_5678, 32'd0, "mthi");
    chk("mthi hi const", hi, 32'h1234_5678);
    do_op(3'd6, 32'hCAFE_F00D, 32'd0, "mtlo");

    // mtlo issued during RUN is ignored
    model_op(3'd1, 32'd6, 32'd7, lat);
    start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
    tick();
    start = 1'b0; op = 3'd0;
    tick();
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; op = 3'd0;
    cnt = 2;
    while (busy === 1'b1 && cnt < 64) begin cnt++; tick(); end
    chk("mtlo in run busy_cycles", 32'(cnt), 32'(lat));
    chk("mtlo in run lo", lo, lo_m);
    chk("mtlo in run hi", hi, hi_m);

    // Cancel in the 3rd busy cycle
    start = 1'b1; op = 3'd1; a = 32'd100; b = 32'd100;
    tick();
    start = 1'b0; op = 3'd0;
    tick(); tick();
    chk("cancel pre busy", {31'd0, busy}, 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel busy", {31'd0, busy}, 32'd0);
    repeat (MULT_N) tick();
    chk("cancel hi", hi, hi_m);
    chk("cancel lo", lo, lo_m);

    // start and cancel together
    start = 1'b1; op = 3'd3; a = 32'd50; b = 32'd5; cancel = 1'b1;
    tick();
    start = 1'b0; op = 3'd0; cancel = 1'b0;
    chk("start+cancel busy", {31'd0, busy}, 32'd0);
    repeat (DIV_N + 1) tick();
    chk("start+cancel lo", lo, lo_m);

    // Reset in 4th busy cycle of div
    start = 1'b1; op = 3'd3; a = 32'd1000; b = 32'd3;
    tick();
    start = 1'b0; op = 3'd0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    hi_m = 32'd0; lo_m = 32'd0;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset hi", hi, 32'd0);
    chk("midreset lo", lo, 32'd0);
    repeat (DIV_N) tick();
    chk("midreset lo stays", lo, 32'd0);
    do_op(3'd1, 32'h0001_0000, 32'h0003_0000, "mult after reset");

    // op 7 (madd when enabled, otherwise no-op) and op 0
    do_op(3'd5, 32'd0, 32'd0, "mthi 0");
    do_op(3'd6, 32'hFFFF_FFFF, 32'd0, "mtlo ff");
    do_op(3'd7, 32'd1, 32'd1, "op7");
`ifdef MD_MADD_EN
    chk("madd hi const", hi, 32'd1);
    chk("madd lo const", lo, 32'd0);
`else
    chk("op7 lo const", lo, 32'hFFFF_FFFF);
`endif
    do_op(3'd0, 32'h5555_5555, 32'd9, "op0");

    // Random ops, back-to-back
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 9));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      do_op(ro, ra, rb, $sformatf("rand%0d op%0d", i, ro));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
